// File: rtl/mips_decode_regfile_pkg.sv
// Shared constants for the MIPS ID-stage decode core: opcodes, SPECIAL
// function codes, REGIMM rt selectors and the decoded control bundle.
package mips_decode_regfile_pkg;

  localparam int ALUC_W = 6;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_LL      = 6'h30;
  localparam logic [5:0] OP_SC      = 6'h38;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  localparam logic [4:0] REG_RA     = 5'd31;

  typedef struct packed {
    logic link;
    logic reg_dest;
    logic jump;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic reg_write;
    logic jump_register;
    logic sign_or_zero;
    logic syscall;
  } ctrl_t;

endpackage

// File: rtl/mips_decode_regfile_regfile.sv
// 32x32 architectural register file: three combinational read ports, one
// write port, r0 hard-wired to zero, asynchronous active-high clear.
// With REGFILE_BYPASS_EN defined, a pending write is forwarded to any read
// port addressing the same register in the same cycle.
module mips_decode_regfile_regfile
  import mips_decode_regfile_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  input  logic [4:0]  raddr_c_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o,
  output logic [31:0] rdata_c_o
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        wr_en;

  assign wr_en = we_i && (waddr_i != 5'd0);

  // Next-state of the array: at most one register updated per edge.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[waddr_i] = wdata_i;
  end

  // Register storage; reset clears every entry without waiting for a clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports; r0 is forced to zero rather than trusting the stored entry.
  always_comb begin
    rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regs_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regs_q[raddr_b_i];
    rdata_c_o = (raddr_c_i == 5'd0) ? 32'd0 : regs_q[raddr_c_i];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
    if (wr_en && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
    if (wr_en && (waddr_i == raddr_c_i)) rdata_c_o = wdata_i;
`endif
  end

endmodule

// File: rtl/mips_decode_regfile.sv
// MIPS ID-stage core: combinational instruction decode, register-file reads
// for rs/rt/destination, and branch/jump target generation.
// Optional build macro: REGFILE_BYPASS_EN (write-through on read ports).
module mips_decode_regfile
  import mips_decode_regfile_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       Instr,
  input  logic [31:0]       Instr_PC_Plus4,
  input  logic [4:0]        WriteReg,
  input  logic [31:0]       WriteData,
  input  logic              Write,
  output logic              Link,
  output logic              RegDest,
  output logic              Jump,
  output logic              Branch,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              ALUSrc,
  output logic              RegWrite,
  output logic              JumpRegister,
  output logic              SignOrZero,
  output logic              Syscall,
  output logic [ALUC_W-1:0] ALUControl,
  output logic [4:0]        WriteRegister,
  output logic [31:0]       DataA,
  output logic [31:0]       DataB,
  output logic [31:0]       DataC,
  output logic [31:0]       NextInstructionAddress
);

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  ctrl_t       ctrl;
  logic        known;
  logic [31:0] branch_off;

  assign op    = Instr[31:26];
  assign rs    = Instr[25:21];
  assign rt    = Instr[20:16];
  assign rd    = Instr[15:11];
  assign funct = Instr[5:0];
  assign imm   = Instr[15:0];

  // Control decode; anything unrecognised leaves every control and ALUControl at 0.
  always_comb begin
    ctrl  = '0;
    known = 1'b1;
    unique case (op)
      OP_SPECIAL: begin
        unique case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            ctrl.reg_dest  = 1'b1;
            ctrl.reg_write = 1'b1;
          end
          FN_JR: begin
            ctrl.jump          = 1'b1;
            ctrl.jump_register = 1'b1;
          end
          FN_JALR: begin
            ctrl.jump          = 1'b1;
            ctrl.jump_register = 1'b1;
            ctrl.link          = 1'b1;
            ctrl.reg_dest      = 1'b1;
            ctrl.reg_write     = 1'b1;
          end
          FN_SYSCALL: ctrl.syscall = 1'b1;
          default:    known = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        ctrl.alu_src      = 1'b1;
        ctrl.reg_write    = 1'b1;
        ctrl.sign_or_zero = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LL: begin
        ctrl.mem_read     = 1'b1;
        ctrl.reg_write    = 1'b1;
        ctrl.alu_src      = 1'b1;
        ctrl.sign_or_zero = 1'b1;
      end
      OP_SB, OP_SH, OP_SW, OP_SC: begin
        ctrl.mem_write    = 1'b1;
        ctrl.alu_src      = 1'b1;
        ctrl.sign_or_zero = 1'b1;
        ctrl.reg_write    = (op == OP_SC);
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        ctrl.branch       = 1'b1;
        ctrl.sign_or_zero = 1'b1;
      end
      OP_REGIMM: begin
        ctrl.branch       = 1'b1;
        ctrl.sign_or_zero = 1'b1;
        if ((rt == RT_BLTZAL) || (rt == RT_BGEZAL)) begin
          ctrl.link      = 1'b1;
          ctrl.reg_write = 1'b1;
        end
      end
      OP_J:    ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  assign {Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc,
          RegWrite, JumpRegister, SignOrZero, Syscall} = ctrl;

  assign ALUControl    = !known ? '0 : ((op == OP_SPECIAL) ? funct : op);
  assign WriteRegister = ctrl.reg_dest ? rd : (ctrl.link ? REG_RA : rt);
  assign branch_off    = {{14{imm[15]}}, imm, 2'b00};

  // Target select: register jump, then absolute jump, else PC-relative branch.
  always_comb begin
    if (ctrl.jump_register)
      NextInstructionAddress = DataA;
    else if (ctrl.jump)
      NextInstructionAddress = {Instr_PC_Plus4[31:28], Instr[25:0], 2'b00};
    else
      NextInstructionAddress = Instr_PC_Plus4 + branch_off;
  end

  mips_decode_regfile_regfile u_regfile (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .we_i      (Write),
    .waddr_i   (WriteReg),
    .wdata_i   (WriteData),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .raddr_c_i (WriteRegister),
    .rdata_a_o (DataA),
    .rdata_b_o (DataB),
    .rdata_c_o (DataC)
  );

endmodule

// File: tb/tb_mips_decode_regfile.sv
module tb_mips_decode_regfile;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr;
  logic [31:0] Instr_PC_Plus4;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        Write;
  logic        Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc;
  logic        RegWrite, JumpRegister, SignOrZero, Syscall;
  logic [5:0]  ALUControl;
  logic [4:0]  WriteRegister;
  logic [31:0] DataA, DataB, DataC, NextInstructionAddress;

  mips_decode_regfile dut (
    .CLK(CLK), .RESET(RESET), .Instr(Instr), .Instr_PC_Plus4(Instr_PC_Plus4),
    .WriteReg(WriteReg), .WriteData(WriteData), .Write(Write),
    .Link(Link), .RegDest(RegDest), .Jump(Jump), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .JumpRegister(JumpRegister), .SignOrZero(SignOrZero),
    .Syscall(Syscall), .ALUControl(ALUControl), .WriteRegister(WriteRegister),
    .DataA(DataA), .DataB(DataB), .DataC(DataC),
    .NextInstructionAddress(NextInstructionAddress)
  );

  always #5 CLK = ~CLK;

  // Control bit weights: {Link,RegDest,Jump,Branch,MemRead,MemWrite,ALUSrc,RegWrite,JumpRegister,SignOrZero,Syscall}
  localparam logic [10:0] C_LK = 11'h400, C_RD = 11'h200, C_J  = 11'h100, C_BR = 11'h080;
  localparam logic [10:0] C_MR = 11'h040, C_MW = 11'h020, C_AS = 11'h010, C_RW = 11'h008;
  localparam logic [10:0] C_JR = 11'h004, C_SZ = 11'h002, C_SC = 11'h001;

  wire [10:0] ctrl_obs = {Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc,
                          RegWrite, JumpRegister, SignOrZero, Syscall};

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [10:0] ctrl;
    logic [5:0]  aluc;
    logic [4:0]  wreg;
    logic [31:0] nia;
  } dec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge CLK);
    Write = 1'b1; WriteReg = a; WriteData = d;
    @(posedge CLK);
    #1;
    Write = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] obs;
    // r5 reads zero while reset is held
    @(negedge CLK);
    Instr = 32'h00A00000;
    sb_q.push_back('{"reset_r5_initial", 32'h0});
    #1; e = sb_q.pop_front(); obs = DataA; checks++;
    if (obs !== e.value) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.value); end
    @(negedge CLK); RESET = 1'b0;
    do_write(5'd5, 32'h00001234);
    @(negedge CLK);
    sb_q.push_back('{"write_r5", 32'h00001234});
    #1; e = sb_q.pop_front(); obs = DataA; checks++;
    if (obs !== e.value) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.value); end
    // asynchronous clear in the low phase, no clock edge in between
    RESET = 1'b1;
    sb_q.push_back('{"async_reset_r5", 32'h0});
    #1; e = sb_q.pop_front(); obs = DataA; checks++;
    if (obs !== e.value) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.value); end
    // write presented during reset is discarded
    Write = 1'b1; WriteReg = 5'd6; WriteData = 32'h00000055;
    @(posedge CLK); #1; Write = 1'b0;
    @(negedge CLK); RESET = 1'b0; Instr = 32'h00C00000;
    sb_q.push_back('{"write_during_reset_r6", 32'h0});
    #1; e = sb_q.pop_front(); obs = DataA; checks++;
    if (obs !== e.value) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.value); end
    // r0 ignores writes
    do_write(5'd0, 32'h00000005);
    @(negedge CLK); Instr = 32'h00000000;
    sb_q.push_back('{"r0_after_write", 32'h0});
    #1; e = sb_q.pop_front(); obs = DataA; checks++;
    if (obs !== e.value) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.value); end
    // Write=0 must not store
    @(negedge CLK); Write = 1'b0; WriteReg = 5'd5; WriteData = 32'hFFFF0000;
    @(posedge CLK); #1;
    @(negedge CLK); Instr = 32'h00A00000;
    sb_q.push_back('{"no_write_enable_r5", 32'h0});
    #1; e = sb_q.pop_front(); obs = DataA; checks++;
    if (obs !== e.value) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.value); end
  endtask

  task automatic test_regfile_reads();
    exp_t e;
    logic [31:0] obs [3];
    do_write(5'd8,  32'hDEADBEEF);
    do_write(5'd9,  32'h11111111);
    do_write(5'd10, 32'h22222222);
    @(negedge CLK);
    Instr = 32'h012A4020;
    sb_q.push_back('{"add_DataA", 32'h11111111});
    sb_q.push_back('{"add_DataB", 32'h22222222});
    sb_q.push_back('{"add_DataC", 32'hDEADBEEF});
    #1;
    obs[0] = DataA; obs[1] = DataB; obs[2] = DataC;
    for (int k = 0; k < 3; k++) begin
      e = sb_q.pop_front(); checks++;
      if (obs[k] !== e.value) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs[k], e.value); end
    end
  endtask

  task automatic test_decode_table();
    exp_t e;
    logic [31:0] obs [4];
    dec_t tbl [14];
    tbl = '{
      '{32'h012A4020, 32'h00400010, C_RD|C_RW,           6'h20, 5'd8,  32'h00410090},
      '{32'h1000FFFF, 32'h00400010, C_BR|C_SZ,           6'h04, 5'd0,  32'h0040000C},
      '{32'h0C100000, 32'h00400004, C_LK|C_J|C_RW,       6'h03, 5'd31, 32'h00400000},
      '{32'h0000000C, 32'h00400010, C_SC,                6'h0C, 5'd0,  32'h00400040},
      '{32'h8D090004, 32'h00400010, C_MR|C_AS|C_RW|C_SZ, 6'h23, 5'd9,  32'h00400020},
      '{32'h35280F0F, 32'h00400010, C_AS|C_RW,           6'h0D, 5'd8,  32'h00403C4C},
      '{32'h0411FFFE, 32'h00400010, C_BR|C_SZ|C_LK|C_RW, 6'h01, 5'd31, 32'h00400008},
      '{32'hE1090000, 32'h00400010, C_MW|C_AS|C_SZ|C_RW, 6'h38, 5'd9,  32'h00400010},
      '{32'hFC050001, 32'h00400010, 11'h000,             6'h00, 5'd5,  32'h00400014},
      '{32'h0000003F, 32'h00400010, 11'h000,             6'h00, 5'd0,  32'h0040010C},
      '{32'h14000002, 32'hFFFFFFFC, C_BR|C_SZ,           6'h05, 5'd0,  32'h00000004},
      '{32'h08000010, 32'hA0000000, C_J,                 6'h02, 5'd0,  32'hA0000040},
      '{32'h00000000, 32'h00400010, C_RD|C_RW,           6'h00, 5'd0,  32'h00400010},
      '{32'h2509FFFF, 32'h00400010, C_AS|C_RW|C_SZ,      6'h09, 5'd9,  32'h0040000C}
    };
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      Instr = tbl[i].instr;
      Instr_PC_Plus4 = tbl[i].pc4;
      sb_q.push_back('{$sformatf("dec%0d_ctrl", i), {21'd0, tbl[i].ctrl}});
      sb_q.push_back('{$sformatf("dec%0d_aluc", i), {26'd0, tbl[i].aluc}});
      sb_q.push_back('{$sformatf("dec%0d_wreg", i), {27'd0, tbl[i].wreg}});
      sb_q.push_back('{$sformatf("dec%0d_nia", i),  tbl[i].nia});
      #1;
      obs[0] = {21'd0, ctrl_obs}; obs[1] = {26'd0, ALUControl};
      obs[2] = {27'd0, WriteRegister}; obs[3] = NextInstructionAddress;
      for (int k = 0; k < 4; k++) begin
        e = sb_q.pop_front(); checks++;
        if (obs[k] !== e.value) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs[k], e.value); end
      end
    end
  endtask

  task automatic test_jump_register();
    exp_t e;
    logic [31:0] obs [4];
    logic [31:0] same_cycle;
`ifdef REGFILE_BYPASS_EN
    same_cycle = 32'h00400200;
`else
    same_cycle = 32'h00400100;
`endif
    do_write(5'd31, 32'h00400100);
    @(negedge CLK);
    Instr = 32'h03E00008; Instr_PC_Plus4 = 32'h00400010;
    sb_q.push_back('{"jr_ctrl", {21'd0, C_J|C_JR}});
    sb_q.push_back('{"jr_nia", 32'h00400100});
    #1;
    obs[0] = {21'd0, ctrl_obs}; obs[1] = NextInstructionAddress;
    for (int k = 0; k < 2; k++) begin
      e = sb_q.pop_front(); checks++;
      if (obs[k] !== e.value) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs[k], e.value); end
    end
    // concurrent writeback to r31
    @(negedge CLK);
    Write = 1'b1; WriteReg = 5'd31; WriteData = 32'h00400200;
    sb_q.push_back('{"jr_same_cycle_nia", same_cycle});
    sb_q.push_back('{"jr_same_cycle_DataA", same_cycle});
    #1;
    obs[0] = NextInstructionAddress; obs[1] = DataA;
    for (int k = 0; k < 2; k++) begin
      e = sb_q.pop_front(); checks++;
      if (obs[k] !== e.value) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs[k], e.value); end
    end
    @(posedge CLK); #1; Write = 1'b0;
    @(negedge CLK);
    sb_q.push_back('{"jr_after_edge_nia", 32'h00400200});
    #1;
    e = sb_q.pop_front(); checks++;
    if (NextInstructionAddress !== e.value) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, NextInstructionAddress, e.value); end
    // jalr $31,$9 with r9 = 0x11111111
    @(negedge CLK);
    Instr = 32'h0120F809;
    sb_q.push_back('{"jalr_ctrl", {21'd0, C_LK|C_RD|C_J|C_RW|C_JR}});
    sb_q.push_back('{"jalr_wreg", 32'd31});
    sb_q.push_back('{"jalr_nia", 32'h11111111});
    sb_q.push_back('{"jalr_DataC", 32'h00400200});
    #1;
    obs[0] = {21'd0, ctrl_obs}; obs[1] = {27'd0, WriteRegister};
    obs[2] = NextInstructionAddress; obs[3] = DataC;
    for (int k = 0; k < 4; k++) begin
      e = sb_q.pop_front(); checks++;
      if (obs[k] !== e.value) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs[k], e.value); end
    end
  endtask

  initial begin
    RESET = 1'b1; Write = 1'b0; WriteReg = '0; WriteData = '0;
    Instr = '0; Instr_PC_Plus4 = '0;
    repeat (2) @(negedge CLK);
    test_reset();
    test_regfile_reads();
    test_decode_table();
    test_jump_register();
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
